// File: rtl/mac_accum_ctrl_if.sv
// Handshake and multiply-add side-channel bundle for mac_accum_ctrl.
// The slave modport is the controller's view; master is the driver/stage side.
interface mac_accum_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [15:0]      value;
    logic [15:0]      weight;
    logic             last;
    logic             mac_mode;
    logic [15:0]      mac_value;
    logic [15:0]      mac_weight;
    logic [27:0]      mac_ints;
    logic [17:0]      mac_fps;
    logic [27:0]      mac_intr;
    logic [17:0]      mac_fpr;
    logic             out_valid;
    logic             out_ready;
    logic [27:0]      out_int;
    logic [17:0]      out_fp;
    logic             out_mode;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport slave (
        input  in_valid, mode, value, weight, last, mac_intr, mac_fpr, out_ready,
        output in_ready, mac_mode, mac_value, mac_weight, mac_ints, mac_fps,
               out_valid, out_int, out_fp, out_mode, out_cnt, out_ovf
    );

    modport master (
        output in_valid, mode, value, weight, last, mac_intr, mac_fpr, out_ready,
        input  in_ready, mac_mode, mac_value, mac_weight, mac_ints, mac_fps,
               out_valid, out_int, out_fp, out_mode, out_cnt, out_ovf
    );
endinterface

// File: rtl/mac_accum_ctrl.sv
// Vector accumulate controller around an external multiply-add stage.
// Optional macro MAC_ACC_INT_SAT_EN: saturate int8 accumulation instead of wrapping.
module mac_accum_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mac_accum_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [27:0]      r_acc_int;
    logic [17:0]      r_acc_fp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_ovf;
    logic             r_out_valid;
    logic             r_in_ready;

    logic             w_beat;
    logic             w_mode;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [27:0]      w_acc_base;
    logic [27:0]      w_int_nxt;

`ifdef MAC_ACC_INT_SAT_EN
    // The stage's addend is recovered as result - accumulator to detect signed overflow.
    function automatic logic [27:0] sat_add(input logic [27:0] acc, input logic [27:0] res);
        logic [27:0] prod;
        prod = res - acc;
        if ((acc[27] == prod[27]) && (res[27] != acc[27])) begin
            sat_add = acc[27] ? 28'h8000000 : 28'h7FFFFFF;
        end else begin
            sat_add = res;
        end
    endfunction
`endif

    assign w_beat    = bus.in_valid & r_in_ready;
    assign w_mode    = (r_state == IDLE) ? bus.mode : r_mode;
    assign w_cnt_nxt = (r_state == IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);

    // Accumulator view presented to the stage and the value captured on a beat.
    always_comb begin
        w_acc_base = (r_state == IDLE) ? 28'd0 : r_acc_int;
`ifdef MAC_ACC_INT_SAT_EN
        if (!w_mode) begin
            w_int_nxt = sat_add(w_acc_base, bus.mac_intr);
        end else begin
            w_int_nxt = bus.mac_intr;
        end
`else
        w_int_nxt = bus.mac_intr;
`endif
    end

    // Vector FSM with all state and outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc_int   <= 28'd0;
            r_acc_fp    <= 18'd0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE, ACC: begin
                    if (w_beat) begin
                        if (r_state == IDLE) begin
                            r_mode <= bus.mode;
                        end
                        r_acc_int <= w_int_nxt;
                        r_acc_fp  <= bus.mac_fpr;
                        r_cnt     <= w_cnt_nxt;
                        if (bus.last || (w_cnt_nxt == CNT_MAX)) begin
                            r_state     <= DONE;
                            r_ovf       <= ~bus.last;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.mac_mode   = w_mode;
    assign bus.mac_value  = bus.value;
    assign bus.mac_weight = bus.weight;
    assign bus.mac_ints   = w_acc_base;
    assign bus.mac_fps    = (r_state == IDLE) ? 18'd0 : r_acc_fp;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_int    = r_acc_int;
    assign bus.out_fp     = r_acc_fp;
    assign bus.out_mode   = r_mode;
    assign bus.out_cnt    = r_cnt;
    assign bus.out_ovf    = r_ovf;
endmodule

// File: doc/mac_accum_ctrl.md
MAC_ACCUM_CTRL -- requirements
Module: mac_accum_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 8, beat-counter width; max vector length 2^CNT_W-1 beats.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  operand beat valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts beat.
REQ-006 SHALL have port: mode  input  1  1-fp16 0-int8, sampled on first beat of a vector.
REQ-007 SHALL have port: value, weight  input  16 each  operand pair.
REQ-008 SHALL have port: last  input  1  final beat of the vector.
REQ-009 SHALL have port: mac_mode  output  1  mode to the downstream multiply-add stage.
REQ-010 SHALL have port: mac_value, mac_weight  output  16 each  operands to the multiply-add stage.
REQ-011 SHALL have port: mac_ints  output  28  int8 bias to the multiply-add stage.
REQ-012 SHALL have port: mac_fps  output  18  fp16 bias {e[4:0], m[12:0]} to the multiply-add stage.
REQ-013 SHALL have port: mac_intr  input  28  int8 result from the multiply-add stage, same cycle.
REQ-014 SHALL have port: mac_fpr  input  18  fp result from the multiply-add stage, same cycle.
REQ-015 SHALL have port: out_valid  input-side output  1  result valid; out_ready  input  1  consumer ready.
REQ-016 SHALL have port: out_int  output  28; out_fp  output  18; out_mode  output  1; out_cnt  output  CNT_W; out_ovf  output  1.

Function
REQ-017 SHALL implement FSM states IDLE, ACC, DONE.
REQ-018 SHALL drive mac_value/mac_weight directly from value/weight; mac_mode = mode in IDLE, latched mode in ACC/DONE.
REQ-019 SHALL drive mac_ints/mac_fps from accumulator registers acc_int/acc_fp; in IDLE both SHALL be forced to 0.
REQ-020 SHALL assert in_ready in IDLE and ACC, deassert in DONE; beat accepted when in_valid & in_ready.
REQ-021 On accepted beat SHALL register acc_int <= mac_intr, acc_fp <= mac_fpr, count <= count+1.
REQ-022 In IDLE, accepted beat SHALL latch mode, set count to 1, and go to ACC, or DONE if last.
REQ-023 In ACC, accepted beat with last SHALL go to DONE; otherwise stay in ACC; mode input ignored.
REQ-024 Beat making count equal 2^CNT_W-1 without last SHALL force DONE and set out_ovf=1; with last, out_ovf=0.
REQ-025 In DONE SHALL assert out_valid with out_int=acc_int, out_fp=acc_fp, out_mode, out_cnt=count stable until out_ready.
REQ-026 out_valid & out_ready SHALL return to IDLE next cycle, clear count and out_ovf; earliest next beat accepted in that IDLE cycle.
REQ-027 Latency: out_valid SHALL rise the cycle after the last accepted beat.
REQ-028 in_valid low in ACC SHALL hold all state (bubbles allowed, no timeout).
REQ-029 out_int/out_fp SHALL be registers, not combinational from mac_* inputs.

Reset
REQ-030 rst SHALL, on clock edge, set state IDLE, acc_int=0, acc_fp=0, count=0, out_valid=0, out_ovf=0, out_mode=0; in_ready=1 after reset.
REQ-031 rst in ACC or DONE SHALL abandon the vector with no output produced; rst dominates all other events in the same cycle.

Configuration
REQ-032 Macro MAC_ACC_INT_SAT_EN: when defined, int8-mode accumulate SHALL clamp to 28'h7FFFFFF / 28'h8000000 when the signed 28-bit add overflows (acc sign equals product sign, result sign differs), and stay clamped; when undefined, acc_int SHALL take mac_intr unmodified (two's-complement wrap). fp16 path unaffected either way.

Verification
REQ-033 int8, value=3, weight=8'hFE, 4 beats, last on 4th -> out_valid next cycle, out_int=28'hFFFFFE8 (-24), out_cnt=4, out_ovf=0, out_mode=0.
REQ-034 Single beat with last from IDLE, value=5, weight=7 -> DONE next cycle, out_int=35, out_cnt=1; mac_ints=0 during the beat.
REQ-035 out_ready low 3 cycles in DONE -> out_valid held, outputs stable, in_ready=0, beats with in_valid=1 not consumed.
REQ-036 CNT_W=2, 3 beats without last -> forced DONE after 3rd, out_cnt=3, out_ovf=1; fp16 mode: mac_fps each beat equals prior-cycle mac_fpr.
REQ-037 rst pulse after 2 ACC beats -> next cycle state IDLE, mac_ints=0, out_valid=0; new vector starts count at 1.
REQ-038 MAC_ACC_INT_SAT_EN defined, acc_int=28'h7FFFFF0, mac product +127 -> out_int=28'h7FFFFFF; undefined -> wraps negative.
